multi_lane_fifo: RTL and testbench

- Circular FIFO with a variable number of words per beat.
- Per cycle: writes 1..PAR_WRITE lanes and reads 1..PAR_READ lanes, counts chosen per beat.
- Tracks exact occupancy, so all DEPTH slots are usable (no spare slot).
- Generalised successor of the fixed-rate PE buffers; feeds filter/ifmap/psum scratchpads where producer and consumer widths differ.

---
 rtl/fifo_pkg.sv | 32 +++
 rtl/lane_regfile.sv | 44 ++++
 rtl/multi_lane_fifo.sv | 125 ++++++++++++
 tb/tb_multi_lane_fifo.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared width helpers and modular pointer arithmetic for the multi-lane FIFO.
//   calc_aw   : address width for DEPTH slots (at least 1 bit)
//   calc_cw   : width able to hold 0..DEPTH
//   calc_wcw  : width able to hold 0..PAR_WRITE
//   calc_rcw  : width able to hold 0..PAR_READ
//   wrap_add  : (ptr + n) folded back into 0..depth-1, valid for n <= depth
package fifo_pkg;

  function automatic int calc_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int calc_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int calc_wcw(input int par_write);
    return $clog2(par_write + 1);
  endfunction

  function automatic int calc_rcw(input int par_read);
    return $clog2(par_read + 1);
  endfunction

  // Single conditional subtract is enough because ptr < depth and n <= depth.
  function automatic int wrap_add(input int ptr, input int n, input int depth);
    int s;
    s = ptr + n;
    return (s >= depth) ? (s - depth) : s;
  endfunction

endpackage

// File: rtl/lane_regfile.sv
// DEPTH x DATA_WIDTH storage with PAR_WRITE wrapped write ports and
// PAR_READ wrapped combinational read ports. Storage is not reset.
//   clk     : clock
//   lane_we : per-lane write enable, lane i writes slot (wptr + i) mod DEPTH
//   wptr    : base write address
//   wdata   : PAR_WRITE packed words, lane 0 in LSBs
//   rptr    : base read address
//   rdata   : PAR_READ packed words, lane j = slot (rptr + j) mod DEPTH
module lane_regfile
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PAR_WRITE  = 2,
  parameter int PAR_READ   = 3,
  parameter int DEPTH      = 8,
  localparam int AW        = calc_aw(DEPTH)
) (
  input  logic                           clk,
  input  logic [PAR_WRITE-1:0]           lane_we,
  input  logic [AW-1:0]                  wptr,
  input  logic [PAR_WRITE*DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]                  rptr,
  output logic [PAR_READ*DATA_WIDTH-1:0]  rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Enabled lanes always target distinct slots, so no write collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PAR_WRITE; i++) begin
      if (lane_we[i]) begin
        mem[AW'(wrap_add(int'(wptr), i, DEPTH))] <= wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int j = 0; j < PAR_READ; j++) begin
      rdata[j*DATA_WIDTH +: DATA_WIDTH] = mem[AW'(wrap_add(int'(rptr), j, DEPTH))];
    end
  end

endmodule

// File: rtl/multi_lane_fifo.sv
// Circular FIFO accepting 1..PAR_WRITE words and delivering 1..PAR_READ words
// per beat. Exact occupancy is tracked so every slot is usable.
//   clk, rstn        : clock, asynchronous active-low reset
//   clear            : synchronous flush of pointers, count and error flags
//   wen/wcount/din   : write request, word count, packed words (lane 0 oldest)
//   wready           : room for a full PAR_WRITE beat
//   ren/rcount       : read request and pop count
//   dout/rvalid      : head words (first-word-fall-through), valid lane count
//   count            : occupancy
//   full/empty/almost_full/almost_empty : combinational from count
//   overflow_err/underflow_err          : sticky rejected write/read
module multi_lane_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PAR_WRITE  = 2,
  parameter int PAR_READ   = 3,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  localparam int AW        = calc_aw(DEPTH),
  localparam int CW        = calc_cw(DEPTH),
  localparam int WCW       = calc_wcw(PAR_WRITE),
  localparam int RCW       = calc_rcw(PAR_READ)
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            clear,
  input  logic                            wen,
  input  logic [WCW-1:0]                  wcount,
  input  logic [PAR_WRITE*DATA_WIDTH-1:0] din,
  output logic                            wready,
  input  logic                            ren,
  input  logic [RCW-1:0]                  rcount,
  output logic [PAR_READ*DATA_WIDTH-1:0]  dout,
  output logic [RCW-1:0]                  rvalid,
  output logic [CW-1:0]                   count,
  output logic                            full,
  output logic                            empty,
  output logic                            almost_full,
  output logic                            almost_empty,
  output logic                            overflow_err,
  output logic                            underflow_err
);

  logic [AW-1:0]        wptr, rptr;
  logic [AW-1:0]        wptr_nxt, rptr_nxt;
  logic [AW:0]          wsum, rsum;
  logic [CW-1:0]        cnt, cnt_nxt, space;
  logic [CW-1:0]        wc_ext, rc_ext;
  logic                 wr_acc, rd_acc;
  logic                 ovf, udf;
  logic [PAR_WRITE-1:0] lane_we;

  assign wc_ext = CW'(wcount);
  assign rc_ext = CW'(rcount);
  assign space  = CW'(DEPTH) - cnt;

  // Acceptance uses the pre-edge count only; a read never sees a same-cycle write.
  assign wr_acc = wen && (wcount != '0) && (wcount <= WCW'(PAR_WRITE)) && (wc_ext <= space);
  assign rd_acc = ren && (rcount != '0) && (rcount <= RCW'(PAR_READ)) && (rc_ext <= cnt);

  // AW+1 bits hold ptr + n without overflow since ptr < DEPTH <= 2**AW and n <= DEPTH.
  assign wsum     = {1'b0, wptr} + (AW+1)'(wcount);
  assign rsum     = {1'b0, rptr} + (AW+1)'(rcount);
  assign wptr_nxt = (wsum >= (AW+1)'(DEPTH)) ? AW'(wsum - (AW+1)'(DEPTH)) : wsum[AW-1:0];
  assign rptr_nxt = (rsum >= (AW+1)'(DEPTH)) ? AW'(rsum - (AW+1)'(DEPTH)) : rsum[AW-1:0];

  assign cnt_nxt = cnt + (wr_acc ? wc_ext : '0) - (rd_acc ? rc_ext : '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      udf  <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr_nxt;
      if (rd_acc) rptr <= rptr_nxt;
      cnt <= cnt_nxt;
      if (wen && !wr_acc) ovf <= 1'b1;
      if (ren && !rd_acc) udf <= 1'b1;
    end
  end

  // Lanes at or beyond wcount are dropped; clear discards the whole beat.
  always_comb begin
    lane_we = '0;
    for (int i = 0; i < PAR_WRITE; i++) begin
      lane_we[i] = wr_acc && !clear && (WCW'(i) < wcount);
    end
  end

  lane_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .PAR_WRITE  (PAR_WRITE),
    .PAR_READ   (PAR_READ),
    .DEPTH      (DEPTH)
  ) u_regfile (
    .clk     (clk),
    .lane_we (lane_we),
    .wptr    (wptr),
    .wdata   (din),
    .rptr    (rptr),
    .rdata   (dout)
  );

  assign count         = cnt;
  assign wready        = (space >= CW'(PAR_WRITE));
  assign rvalid        = (cnt >= CW'(PAR_READ)) ? RCW'(PAR_READ) : RCW'(cnt);
  assign full          = (cnt == CW'(DEPTH));
  assign empty         = (cnt == '0);
  assign almost_full   = (cnt >= CW'(AF_LEVEL));
  assign almost_empty  = (cnt <= CW'(AE_LEVEL));
  assign overflow_err  = ovf;
  assign underflow_err = udf;

endmodule

// File: tb/tb_multi_lane_fifo.sv
module tb_multi_lane_fifo;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clear;
  logic        wen;
  logic [1:0]  wcount;
  logic [31:0] din;
  logic        wready;
  logic        ren;
  logic [1:0]  rcount;
  logic [47:0] dout;
  logic [1:0]  rvalid;
  logic [3:0]  count;
  logic        full, empty, almost_full, almost_empty;
  logic        overflow_err, underflow_err;

  int checks = 0;
  int errors = 0;

  multi_lane_fifo #(
    .DATA_WIDTH (16),
    .PAR_WRITE  (2),
    .PAR_READ   (3),
    .DEPTH      (8),
    .AF_LEVEL   (7),
    .AE_LEVEL   (1)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .clear         (clear),
    .wen           (wen),
    .wcount        (wcount),
    .din           (din),
    .wready        (wready),
    .ren           (ren),
    .rcount        (rcount),
    .dout          (dout),
    .rvalid        (rvalid),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  // Apply one beat, take the edge, sample #1 after it with inputs idle.
  task automatic beat(input logic w, input logic [1:0] wc, input logic [15:0] l1,
                      input logic [15:0] l0, input logic r, input logic [1:0] rc,
                      input logic clr);
    wen = w; wcount = wc; din = {l1, l0}; ren = r; rcount = rc; clear = clr;
    @(posedge clk); #1;
    wen = 1'b0; ren = 1'b0; clear = 1'b0; wcount = 2'd0; rcount = 2'd0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; clear = 1'b0; wen = 1'b0; ren = 1'b0; wcount = 2'd0; rcount = 2'd0; din = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    checks++; if (count !== 4'd0)        begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1)        begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got %b exp 1", almost_empty); end
    checks++; if (rvalid !== 2'd0)       begin errors++; $display("FAIL reset_rvalid got %0d exp 0", rvalid); end
    checks++; if (wready !== 1'b1)       begin errors++; $display("FAIL reset_wready got %b exp 1", wready); end
    checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b%b exp 00", full, almost_full); end
    checks++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b exp 00", overflow_err, underflow_err); end
  endtask

  task automatic test_fill;
    for (int k = 0; k < 4; k++) begin
      beat(1'b1, 2'd2, 16'h00A0 + 16'(2*k+1), 16'h00A0 + 16'(2*k), 1'b0, 2'd0, 1'b0);
      checks++; if (count !== 4'(2*k+2)) begin errors++; $display("FAIL fill_count got %0d exp %0d", count, 2*k+2); end
    end
    checks++; if (full !== 1'b1)        begin errors++; $display("FAIL fill_full got %b exp 1", full); end
    checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL fill_af got %b exp 1", almost_full); end
    checks++; if (wready !== 1'b0)      begin errors++; $display("FAIL fill_wready got %b exp 0", wready); end
    checks++; if (rvalid !== 2'd3)      begin errors++; $display("FAIL fill_rvalid got %0d exp 3", rvalid); end
    beat(1'b1, 2'd1, 16'h0000, 16'h00EE, 1'b0, 2'd0, 1'b0);
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL fill_ovf got %b exp 1", overflow_err); end
    checks++; if (count !== 4'd8)        begin errors++; $display("FAIL fill_ovf_count got %0d exp 8", count); end
  endtask

  task automatic test_drain;
    logic [15:0] exp_l0 [3];
    exp_l0[0] = 16'h00A0; exp_l0[1] = 16'h00A3; exp_l0[2] = 16'h00A6;
    for (int k = 0; k < 2; k++) begin
      checks++; if (dout[15:0] !== exp_l0[k]) begin errors++; $display("FAIL drain_l0 got %h exp %h", dout[15:0], exp_l0[k]); end
      checks++; if (dout[47:16] !== {exp_l0[k] + 16'd2, exp_l0[k] + 16'd1}) begin errors++; $display("FAIL drain_l12 got %h exp %h", dout[47:16], {exp_l0[k] + 16'd2, exp_l0[k] + 16'd1}); end
      beat(1'b0, 2'd0, 16'h0, 16'h0, 1'b1, 2'd3, 1'b0);
    end
    checks++; if (count !== 4'd2 || rvalid !== 2'd2) begin errors++; $display("FAIL drain_mid got count %0d rvalid %0d exp 2 2", count, rvalid); end
    checks++; if (dout[31:0] !== {16'h00A7, 16'h00A6}) begin errors++; $display("FAIL drain_tail got %h exp 00a700a6", dout[31:0]); end
    beat(1'b0, 2'd0, 16'h0, 16'h0, 1'b1, 2'd2, 1'b0);
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL drain_end got count %0d empty %b exp 0 1", count, empty); end
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL drain_sticky got %b exp 1", overflow_err); end
  endtask

  task automatic test_wrap;
    for (int k = 0; k < 3; k++)
      beat(1'b1, 2'd2, 16'h00B0 + 16'(2*k+1), 16'h00B0 + 16'(2*k), 1'b0, 2'd0, 1'b0);
    checks++; if (dout !== {16'h00B2, 16'h00B1, 16'h00B0}) begin errors++; $display("FAIL wrap_r1 got %h exp 00b200b100b0", dout); end
    beat(1'b0, 2'd0, 16'h0, 16'h0, 1'b1, 2'd3, 1'b0);
    checks++; if (dout[31:0] !== {16'h00B4, 16'h00B3}) begin errors++; $display("FAIL wrap_r2 got %h exp 00b400b3", dout[31:0]); end
    beat(1'b0, 2'd0, 16'h0, 16'h0, 1'b1, 2'd2, 1'b0);
    checks++; if (count !== 4'd1 || dout[15:0] !== 16'h00B5) begin errors++; $display("FAIL wrap_left got count %0d l0 %h exp 1 00b5", count, dout[15:0]); end
    beat(1'b1, 2'd2, 16'h00B7, 16'h00B6, 1'b0, 2'd0, 1'b0);
    beat(1'b1, 2'd2, 16'h00B9, 16'h00B8, 1'b0, 2'd0, 1'b0);
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL wrap_count got %0d exp 5", count); end
    checks++; if (dout !== {16'h00B7, 16'h00B6, 16'h00B5}) begin errors++; $display("FAIL wrap_r3 got %h exp 00b700b600b5", dout); end
    beat(1'b0, 2'd0, 16'h0, 16'h0, 1'b1, 2'd3, 1'b0);
    checks++; if (dout[31:0] !== {16'h00B9, 16'h00B8}) begin errors++; $display("FAIL wrap_r4 got %h exp 00b900b8", dout[31:0]); end
    beat(1'b0, 2'd0, 16'h0, 16'h0, 1'b1, 2'd2, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", empty); end
    // Aligned pointers: a single new word must surface at lane 0.
    beat(1'b1, 2'd1, 16'h0000, 16'h00F0, 1'b0, 2'd0, 1'b0);
    checks++; if (dout[15:0] !== 16'h00F0 || rvalid !== 2'd1) begin errors++; $display("FAIL wrap_align got l0 %h rvalid %0d exp 00f0 1", dout[15:0], rvalid); end
    beat(1'b0, 2'd0, 16'h0, 16'h0, 1'b1, 2'd1, 1'b0);
  endtask

  task automatic test_simultaneous;
    beat(1'b1, 2'd2, 16'h00C1, 16'h00C0, 1'b0, 2'd0, 1'b0);
    beat(1'b1, 2'd2, 16'h00C3, 16'h00C2, 1'b1, 2'd3, 1'b0);
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL simul_udf got %b exp 1", underflow_err); end
    checks++; if (count !== 4'd4)         begin errors++; $display("FAIL simul_count got %0d exp 4", count); end
    checks++; if (dout !== {16'h00C2, 16'h00C1, 16'h00C0}) begin errors++; $display("FAIL simul_data got %h exp 00c200c100c0", dout); end
    beat(1'b1, 2'd1, 16'h0000, 16'h00C4, 1'b1, 2'd2, 1'b0);
    checks++; if (count !== 4'd3 || dout !== {16'h00C4, 16'h00C3, 16'h00C2}) begin errors++; $display("FAIL simul_both got count %0d dout %h exp 3 00c400c300c2", count, dout); end
  endtask

  task automatic test_clear;
    beat(1'b1, 2'd2, 16'h00C6, 16'h00C5, 1'b0, 2'd0, 1'b0);
    checks++; if (count !== 4'd5 || almost_empty !== 1'b0) begin errors++; $display("FAIL clear_pre got count %0d ae %b exp 5 0", count, almost_empty); end
    beat(1'b1, 2'd0, 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b0);
    checks++; if (overflow_err !== 1'b1 || count !== 4'd5) begin errors++; $display("FAIL clear_wc0 got ovf %b count %0d exp 1 5", overflow_err, count); end
    beat(1'b1, 2'd2, 16'h00D1, 16'h00D0, 1'b1, 2'd1, 1'b1);
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL clear_count got count %0d empty %b exp 0 1", count, empty); end
    checks++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin errors++; $display("FAIL clear_err got %b%b exp 00", overflow_err, underflow_err); end
    beat(1'b1, 2'd1, 16'h0000, 16'h00E0, 1'b0, 2'd0, 1'b0);
    checks++; if (count !== 4'd1 || dout[15:0] !== 16'h00E0) begin errors++; $display("FAIL clear_after got count %0d l0 %h exp 1 00e0", count, dout[15:0]); end
  endtask

  task automatic test_async_reset;
    beat(1'b0, 2'd0, 16'h0, 16'h0, 1'b1, 2'd0, 1'b0);
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL async_pre_udf got %b exp 1", underflow_err); end
    beat(1'b1, 2'd2, 16'h00E2, 16'h00E1, 1'b0, 2'd0, 1'b0);
    wen = 1'b1; wcount = 2'd2; din = {16'h00E4, 16'h00E3};
    #2 rstn = 1'b0;
    #1;
    checks++; if (count !== 4'd0 || empty !== 1'b1 || rvalid !== 2'd0) begin errors++; $display("FAIL async_state got count %0d empty %b rvalid %0d exp 0 1 0", count, empty, rvalid); end
    checks++; if (underflow_err !== 1'b0 || wready !== 1'b1) begin errors++; $display("FAIL async_flags got udf %b wready %b exp 0 1", underflow_err, wready); end
    wen = 1'b0; wcount = 2'd0;
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL async_after got %0d exp 0", count); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_drain;
    test_wrap;
    test_simultaneous;
    test_clear;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
